xyolo_out_write: RTL and testbench
==================================

Name: xyolo_out_write

Overview:
- Write-side counterpart of the Versat YOLO vector reader: accepts N_LANES result words per cycle from the compute lanes and stores them in per-lane ping-pong internal memories.
- Drains the previous run's bank to external memory through a single databus master port.
- Configured by CPU write-only requests on the Versat config bus; sequenced by the global run/done pair.

Parameters:
- DATA_W, 32, data word width; byte address step = DATA_W/8.
- ADDR_W, 32, external (IO) address width.
- MEM_ADDR_W, 10, internal memory address width; MSB selects the bank, so depth per bank = 2^(MEM_ADDR_W-1).
- N_LANES, 4, number of parallel lanes / internal memories.
- CONF_ADDR_W, 2, config address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clear  in  1  asynchronous clear of config registers only
- run  in  1  one-cycle start pulse
- done  out  1  high when the fill and drain are both complete
- valid  in  1  config request valid
- addr  in  CONF_ADDR_W  config register select
- wdata  in  ADDR_W  config data
- wstrb  in  1  config write enable
- databus_ready  in  1  external write accepted
- databus_valid  out  1  external write request
- databus_addr  out  ADDR_W  external byte address
- databus_rdata  in  DATA_W  unused
- databus_wdata  out  DATA_W  write data
- databus_wstrb  out  DATA_W/8  byte strobes
- flow_in  in  N_LANES*DATA_W  lane data; lane 0 in the MSBs
- flow_in_en  in  1  flow_in valid this cycle

Behaviour:
- Config registers: 0 EXT_ADDR, 1 OFFSET (lane stride in bytes), 2 LEN (vectors per run, ≤ 2^(MEM_ADDR_W-1)), 3 RELU (feature only).
  - Written when valid&wstrb; cleared by rst or clear.
  - Unmapped addresses are ignored.
- On run while done=1:
  - drain_ext/drain_off/drain_len <= fill_ext/fill_off/fill_len.
  - fill_* <= config.
  - bank <= bank ^ (LEN!=0).
  - fill_cnt, drain lane and drain word counters reset to 0.
  - run while done=0 is ignored entirely: no shadow update, no bank toggle.
- Fill:
  - While fill_cnt < fill_len and flow_in_en=1, each lane j writes its word to mem_j[{bank, fill_cnt}] and fill_cnt increments.
  - flow_in_en after fill completes is dropped.
- Drain FSM states: D_IDLE, D_RD, D_REQ.
  - D_IDLE -> D_RD on an accepted run with new drain_len!=0.
  - D_RD: read mem_lane[{~bank, word}]; 1-cycle read latency; -> D_REQ.
  - D_REQ:
    - databus_valid=1; addr = drain_ext + lane*drain_off + word*(DATA_W/8); wdata = registered mem output; wstrb all ones.
    - All four outputs are held stable until ready.
    - On ready: word++. When word==drain_len-1, word<=0 and lane++.
    - On the last lane and word -> D_IDLE; otherwise -> D_RD.
  - Minimum 2 cycles per word; words within a lane are issued before moving to the next lane.
  - Addresses are computed incrementally (lane_base += off, word_addr += DATA_W/8); all sums wrap modulo 2^ADDR_W.
- databus_valid=0, wstrb=0, addr=0, wdata=0 whenever the FSM is not in D_REQ.
- done = (fill_cnt==fill_len) & (state==D_IDLE). It is combinational from registers and deasserts the cycle after an accepted run unless both lengths are 0.
- The first run drains a zero-length bank, so nothing is written. Data becomes visible externally one run later.
- Reset values:
  - done=1, databus_valid=0, all databus outputs 0, bank=0, state D_IDLE, all shadows and counters 0.
  - rst mid-operation aborts the fill and the drain immediately; the pending databus request is dropped.
- clear does not affect shadows or an operation in progress.
- Fill and drain use different banks, so there is no read/write collision.

Optional Feature:
- XYOLO_OUT_WRITE_RELU_EN defined:
  - Config register 3 bit 0 is latched into fill/drain shadows like the others.
  - When set, a drained word with MSB=1 is written as 0, applied in D_RD on the memory output.
- Undefined:
  - Register 3 is unmapped and data passes unchanged; no ReLU logic is present.

Decomposition:
- Shared header: XYOLO_OUT_WRITE_CONF_EXT_ADDR/OFFSET/LEN/RELU addresses, CONF_ADDR_W, drain state encodings.
- Per-lane storage reuses iob_2p_mem.
- One natural sub-module, xyolo_out_drain: drain FSM, address counters and databus handshake, with lane mux input.

Test Plan:
- Reset, no config, run -> done stays 1 (lengths 0), databus_valid never asserts, bank stays 0.
- LEN=3, EXT_ADDR=0x1000, OFFSET=0x100, run, 3 flow_in vectors, then run again with a second config -> 12 writes in order 0x1000,0x1004,0x1008,0x1100,...,0x1308. Data matches lane/vector order; done rises after the last ready.
- databus_ready held low 5 cycles during D_REQ -> addr/wdata/valid stable throughout, no skipped or duplicated word.
- Back-to-back runs with LEN=2 fill bank 1 while bank 0 drains -> drained data is the previous run's data, uncorrupted by the concurrent fill.
- run pulse while done=0 -> ignored; the write count and addresses are unchanged from the run without the extra pulse.
- With XYOLO_OUT_WRITE_RELU_EN and RELU=1, input 0xFFFFFFF0 -> written 0x00000000; input 0x00000010 -> unchanged. rst asserted mid-drain -> valid drops immediately, done=1.

Source files
------------

// File: rtl/xyolo_out_write_pkg.sv
// Shared definitions for the YOLO output writer: config register map and drain FSM encodings.
package xyolo_out_write_pkg;
  localparam int XYOLO_OUT_WRITE_CONF_ADDR_W   = 2;
  localparam int XYOLO_OUT_WRITE_CONF_EXT_ADDR = 0;
  localparam int XYOLO_OUT_WRITE_CONF_OFFSET   = 1;
  localparam int XYOLO_OUT_WRITE_CONF_LEN      = 2;
  localparam int XYOLO_OUT_WRITE_CONF_RELU     = 3;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RD   = 2'd1,
    D_REQ  = 2'd2
  } drain_state_t;
endpackage

// File: rtl/iob_2p_mem.sv
// Simple two-port RAM: one write port, one registered read port (1-cycle latency).
module iob_2p_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
    if (r_en) r_data <= mem[r_addr];
  end
endmodule

// File: rtl/xyolo_out_drain.sv
// Drain engine: walks lanes then words of the idle bank and issues one databus write per word.
// Optional ReLU on drained data when XYOLO_OUT_WRITE_RELU_EN is defined.
module xyolo_out_drain
  import xyolo_out_write_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int N_LANES    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                ext,
  input  logic [ADDR_W-1:0]                off,
  input  logic [MEM_ADDR_W-1:0]            len,
`ifdef XYOLO_OUT_WRITE_RELU_EN
  input  logic                             relu,
`endif
  input  logic [N_LANES-1:0][DATA_W-1:0]   mem_rdata,
  output logic                             rd_en,
  output logic [MEM_ADDR_W-2:0]            rd_word,
  output logic                             idle,
  input  logic                             databus_ready,
  output logic                             databus_valid,
  output logic [ADDR_W-1:0]                databus_addr,
  output logic [DATA_W-1:0]                databus_wdata,
  output logic [DATA_W/8-1:0]              databus_wstrb
);
  localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W/8);

  drain_state_t state, state_nx;
  logic [ADDR_W-1:0]     off_q, lane_base, cur_addr;
  logic [MEM_ADDR_W-1:0] len_q;
  logic [MEM_ADDR_W-2:0] word;
  logic [LANE_W-1:0]     lane;
  logic                  last_word, last_lane, accept;
  logic [DATA_W-1:0]     sel_data, out_data;

  assign last_word = ({1'b0, word} == len_q - MEM_ADDR_W'(1));
  assign last_lane = (lane == LANE_W'(N_LANES-1));
  assign accept    = (state == D_REQ) && databus_ready;
  assign sel_data  = mem_rdata[lane];

`ifdef XYOLO_OUT_WRITE_RELU_EN
  logic relu_q;
  always_ff @(posedge clk or posedge rst)
    if (rst)        relu_q <= 1'b0;
    else if (start) relu_q <= relu;
  assign out_data = (relu_q && sel_data[DATA_W-1]) ? '0 : sel_data;
`else
  assign out_data = sel_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= D_IDLE;
      off_q     <= '0;
      len_q     <= '0;
      word      <= '0;
      lane      <= '0;
      lane_base <= '0;
      cur_addr  <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        off_q     <= off;
        len_q     <= len;
        word      <= '0;
        lane      <= '0;
        lane_base <= ext;
        cur_addr  <= ext;
      end else if (accept) begin
        // Lane change restarts the word address from the next lane base.
        if (last_word) begin
          word      <= '0;
          lane      <= lane + LANE_W'(1);
          lane_base <= lane_base + off_q;
          cur_addr  <= lane_base + off_q;
        end else begin
          word     <= word + 1'b1;
          cur_addr <= cur_addr + STEP;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      D_IDLE: if (start && len != '0) state_nx = D_RD;
      D_RD:   state_nx = D_REQ;
      D_REQ:  if (databus_ready) state_nx = (last_word && last_lane) ? D_IDLE : D_RD;
      default: state_nx = D_IDLE;
    endcase
  end

  always_comb begin
    rd_en         = (state == D_RD);
    rd_word       = word;
    idle          = (state == D_IDLE);
    databus_valid = 1'b0;
    databus_addr  = '0;
    databus_wdata = '0;
    databus_wstrb = '0;
    if (state == D_REQ) begin
      databus_valid = 1'b1;
      databus_addr  = cur_addr;
      databus_wdata = out_data;
      databus_wstrb = '1;
    end
  end
endmodule

// File: rtl/xyolo_out_write.sv
// YOLO output writer: fills per-lane ping-pong banks from flow_in and drains the other bank
// to the databus. Optional ReLU on drain via XYOLO_OUT_WRITE_RELU_EN.
module xyolo_out_write
  import xyolo_out_write_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int N_LANES     = 4,
  parameter int CONF_ADDR_W = XYOLO_OUT_WRITE_CONF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      run,
  output logic                      done,
  input  logic                      valid,
  input  logic [CONF_ADDR_W-1:0]    addr,
  input  logic [ADDR_W-1:0]         wdata,
  input  logic                      wstrb,
  input  logic                      databus_ready,
  output logic                      databus_valid,
  output logic [ADDR_W-1:0]         databus_addr,
  input  logic [DATA_W-1:0]         databus_rdata,
  output logic [DATA_W-1:0]         databus_wdata,
  output logic [DATA_W/8-1:0]       databus_wstrb,
  input  logic [N_LANES*DATA_W-1:0] flow_in,
  input  logic                      flow_in_en
);
  localparam int DEPTH_W = MEM_ADDR_W - 1;

  logic [ADDR_W-1:0]     cfg_ext, cfg_off, fill_ext, fill_off;
  logic [MEM_ADDR_W-1:0] cfg_len, fill_len, fill_cnt;
  logic                  bank, start, fill_we, drain_idle, rd_en;
  logic [DEPTH_W-1:0]    rd_word;
  logic [N_LANES-1:0][DATA_W-1:0] mem_rdata;
  logic                  unused_rdata;

  assign unused_rdata = ^databus_rdata;

  always_ff @(posedge clk or posedge rst or posedge clear) begin
    if (rst || clear) begin
      cfg_ext <= '0;
      cfg_off <= '0;
      cfg_len <= '0;
    end else if (valid && wstrb) begin
      case (addr)
        CONF_ADDR_W'(XYOLO_OUT_WRITE_CONF_EXT_ADDR): cfg_ext <= wdata;
        CONF_ADDR_W'(XYOLO_OUT_WRITE_CONF_OFFSET):   cfg_off <= wdata;
        CONF_ADDR_W'(XYOLO_OUT_WRITE_CONF_LEN):      cfg_len <= wdata[MEM_ADDR_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef XYOLO_OUT_WRITE_RELU_EN
  logic cfg_relu, fill_relu;
  always_ff @(posedge clk or posedge rst or posedge clear)
    if (rst || clear) cfg_relu <= 1'b0;
    else if (valid && wstrb && addr == CONF_ADDR_W'(XYOLO_OUT_WRITE_CONF_RELU)) cfg_relu <= wdata[0];
  always_ff @(posedge clk or posedge rst)
    if (rst)        fill_relu <= 1'b0;
    else if (start) fill_relu <= cfg_relu;
`endif

  assign done    = (fill_cnt == fill_len) && drain_idle;
  assign start   = run && done;
  assign fill_we = flow_in_en && (fill_cnt < fill_len);

  // Drain shadows are loaded inside the drain engine from the outgoing fill shadows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank     <= 1'b0;
      fill_ext <= '0;
      fill_off <= '0;
      fill_len <= '0;
      fill_cnt <= '0;
    end else if (start) begin
      fill_ext <= cfg_ext;
      fill_off <= cfg_off;
      fill_len <= cfg_len;
      fill_cnt <= '0;
      bank     <= bank ^ (cfg_len != '0);
    end else if (fill_we) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  for (genvar j = 0; j < N_LANES; j++) begin : g_lane
    iob_2p_mem #(.DATA_W(DATA_W), .ADDR_W(MEM_ADDR_W)) u_mem (
      .clk    (clk),
      .w_en   (fill_we),
      .w_addr ({bank, fill_cnt[DEPTH_W-1:0]}),
      .w_data (flow_in[(N_LANES-1-j)*DATA_W +: DATA_W]),
      .r_en   (rd_en),
      .r_addr ({~bank, rd_word}),
      .r_data (mem_rdata[j])
    );
  end

  xyolo_out_drain #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .N_LANES(N_LANES)
  ) u_drain (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ext           (fill_ext),
    .off           (fill_off),
    .len           (fill_len),
`ifdef XYOLO_OUT_WRITE_RELU_EN
    .relu          (fill_relu),
`endif
    .mem_rdata     (mem_rdata),
    .rd_en         (rd_en),
    .rd_word       (rd_word),
    .idle          (drain_idle),
    .databus_ready (databus_ready),
    .databus_valid (databus_valid),
    .databus_addr  (databus_addr),
    .databus_wdata (databus_wdata),
    .databus_wstrb (databus_wstrb)
  );
endmodule

// File: tb/tb_xyolo_out_write.sv
// Scoreboard bench for xyolo_out_write: expected writes queued at run, checked on each accepted write.
module tb_xyolo_out_write;
  localparam int DATA_W = 32, ADDR_W = 32, MEM_ADDR_W = 10, N_LANES = 4, CONF_ADDR_W = 2;
`ifdef XYOLO_OUT_WRITE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, clear, run, done, valid, wstrb, flow_in_en;
  logic databus_ready, databus_valid;
  logic [CONF_ADDR_W-1:0]    addr;
  logic [ADDR_W-1:0]         wdata, databus_addr;
  logic [DATA_W-1:0]         databus_rdata, databus_wdata;
  logic [DATA_W/8-1:0]       databus_wstrb;
  logic [N_LANES*DATA_W-1:0] flow_in;

  xyolo_out_write dut (
    .clk(clk), .rst(rst), .clear(clear), .run(run), .done(done),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .databus_ready(databus_ready), .databus_valid(databus_valid),
    .databus_addr(databus_addr), .databus_rdata(databus_rdata),
    .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
    .flow_in(flow_in), .flow_in_en(flow_in_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, n_wr = 0, rdy_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];

  // Reference model: pending config and fill-side shadows with the data fed into them.
  logic [31:0] c_ext, c_off, c_len, m_ext, m_off, m_len;
  logic        c_relu, m_relu;
  logic [31:0] m_data [0:7][0:N_LANES-1];

  // Ready generator
  initial begin
    int cyc = 0;
    databus_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: databus_ready = 1'b1;
        1: databus_ready = 1'($urandom_range(0, 1));
        2: databus_ready = (cyc % 6 == 5);
        default: databus_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  // Monitor: pop/compare accepted writes; check request stability while stalled
  logic        h_vld = 1'b0, h_rdy = 1'b0;
  logic [31:0] h_addr, h_data;
  always @(negedge clk) begin
    wr_t e;
    if (rst) h_vld = 1'b0;
    else begin
      if (h_vld && !h_rdy) begin
        check("hold_vld", databus_valid, 1);
        check("hold_addr", databus_addr, h_addr);
        check("hold_data", databus_wdata, h_data);
      end
      if (databus_valid && databus_ready) begin
        n_wr++;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", databus_addr, e.a);
          check("wr_data", databus_wdata, e.d);
          check("wr_strb", databus_wstrb, 4'hf);
        end
      end
      h_vld = databus_valid; h_rdy = databus_ready;
      h_addr = databus_addr; h_data = databus_wdata;
    end
  end

  task automatic cfg_wr(input int a, input logic [31:0] d);
    valid = 1'b1; wstrb = 1'b1; addr = CONF_ADDR_W'(a); wdata = d;
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 1'b0;
    case (a)
      0: c_ext = d;
      1: c_off = d;
      2: c_len = d;
      default: if (RELU) c_relu = d[0];
    endcase
  endtask

  task automatic cfg_all(input logic [31:0] e, input logic [31:0] o, input logic [31:0] l, input logic r);
    cfg_wr(0, e); cfg_wr(1, o); cfg_wr(2, l); cfg_wr(3, {31'd0, r});
  endtask

  // Accepted run: queue the drain of the previous fill, then shift config into the model.
  task automatic run_acc(input string tag);
    logic [31:0] d;
    logic        exp_done;
    check({tag, "_pre_done"}, done, 1);
    for (int l = 0; l < N_LANES; l++)
      for (int w = 0; w < int'(m_len); w++) begin
        d = m_data[w][l];
        if (m_relu && d[31]) d = '0;
        sb.push_back('{a: m_ext + l * m_off + w * 4, d: d});
      end
    exp_done = (m_len == 0) && (c_len == 0);
    m_ext = c_ext; m_off = c_off; m_len = c_len; m_relu = c_relu;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    check({tag, "_post_done"}, done, exp_done);
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    logic [31:0] d;
    for (int v = 0; v < n; v++) begin
      for (int j = 0; j < N_LANES; j++) begin
        d = base + v * 16 + j;
        if (v == 0 && j == 3) d = 32'h0000_0010;
        if (v == 1 && j == 2) d = 32'hFFFF_FFF0;
        m_data[v][j] = d;
        flow_in[(N_LANES-1-j)*DATA_W +: DATA_W] = d;
      end
      flow_in_en = 1'b1;
      @(posedge clk); #1;
    end
    flow_in_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    int w0;
    rst = 1'b1; clear = 1'b0; run = 1'b0; valid = 1'b0; wstrb = 1'b0;
    addr = '0; wdata = '0; flow_in = '0; flow_in_en = 1'b0; databus_rdata = '0;
    c_ext = 0; c_off = 0; c_len = 0; c_relu = 0;
    m_ext = 0; m_off = 0; m_len = 0; m_relu = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_done", done, 1);
    check("rst_valid", databus_valid, 0);
    check("rst_addr", databus_addr, 0);
    check("rst_wdata", databus_wdata, 0);
    check("rst_wstrb", databus_wstrb, 0);

    // Run with empty config: nothing happens
    run_acc("t1");
    repeat (6) @(posedge clk); #1;
    check("t1_done", done, 1);
    check("t1_nowr", n_wr, 0);

    // First real fill; extra flow_in_en after fill must be dropped
    cfg_all(32'h1000, 32'h100, 3, 1'b1);
    run_acc("t2");
    feed(3, 32'h1100_0000);
    flow_in = {N_LANES{32'hDEAD_BEEF}}; flow_in_en = 1'b1;
    @(posedge clk); #1 flow_in_en = 1'b0;
    wait_done("t2_fill");
    check("t2_nowr", n_wr, 0);

    // Drain 12 words with random ready while filling; ignored run mid-drain
    cfg_all(32'h2000, 32'h40, 2, 1'b0);
    w0 = n_wr; rdy_mode = 1;
    run_acc("t3");
    feed(2, 32'h2200_0000);
    check("t3_busy", done, 0);
    run = 1'b1; @(posedge clk); #1 run = 1'b0;
    wait_done("t3_done");
    check("t3_cnt", n_wr - w0, 12);

    // Long ready stalls
    cfg_all(32'h3000, 32'h8, 2, 1'b1);
    w0 = n_wr; rdy_mode = 2;
    run_acc("t4");
    feed(2, 32'h3300_0000);
    wait_done("t4_done");
    check("t4_cnt", n_wr - w0, 8);

    // Drain of the ReLU-flagged run
    cfg_all(32'h4000, 32'h4, 1, 1'b0);
    w0 = n_wr; rdy_mode = 0;
    run_acc("t5");
    feed(1, 32'h4400_0000);
    wait_done("t5_done");
    check("t5_cnt", n_wr - w0, 8);

    // Reset mid-drain
    cfg_all(32'h4800, 32'h4, 1, 1'b0);
    rdy_mode = 3;
    run_acc("t6");
    for (int k = 0; k < 20 && !databus_valid; k++) begin
      @(posedge clk); #1;
    end
    check("t6_req", databus_valid, 1);
    rst = 1'b1; #1;
    check("t6_valid", databus_valid, 0);
    check("t6_addr", databus_addr, 0);
    check("t6_done", done, 1);
    sb.delete();
    c_ext = 0; c_off = 0; c_len = 0; c_relu = 0;
    m_ext = 0; m_off = 0; m_len = 0; m_relu = 0;
    rdy_mode = 0;
    @(posedge clk); #1 rst = 1'b0;

    // clear wipes config: a run afterwards has zero length
    cfg_wr(2, 5);
    clear = 1'b1; #2 clear = 1'b0;
    c_len = 0;
    run_acc("t6c");

    // Clean operation after reset
    cfg_all(32'h5000, 32'h10, 1, 1'b0);
    run_acc("t7a");
    feed(1, 32'h5500_0000);
    wait_done("t7a_done");
    w0 = n_wr;
    run_acc("t7b");
    feed(1, 32'h5600_0000);
    wait_done("t7b_done");
    check("t7_cnt", n_wr - w0, 4);

    repeat (3) @(posedge clk); #1;
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
